fifo_rd_ctrl: RTL and testbench

Read-side controller for the asynchronous FIFO. It runs entirely in the read clock domain and synchronizes the Gray-coded write pointer from the write domain. It drives the read address of the dual-port RAM's read port, which has one-cycle registered read latency and its write enable tied low. It presents data to the consumer through a two-entry valid/ready output buffer in first-word-fall-through order, and returns its own Gray read pointer to the write domain for full detection.

---
 rtl/fifo_rd_ctrl.sv | 105 ++++++++++
 tb/tb_fifo_rd_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - async FIFO read-side controller with two-entry FWFT output buffer
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [ADDR_WIDTH:0]   i_wr_ptr_gray,
    input  logic [DATA_WIDTH-1:0] i_ram_data,
    input  logic                  i_rd_ready,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic                  o_rd_fetch,
    output logic [ADDR_WIDTH:0]   o_rd_ptr_gray,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_empty,
    output logic [ADDR_WIDTH:0]   o_level
);
    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0]         sync1_q, sync2_q;
    logic [PW-1:0]         rd_bin_q, rd_bin_d;
    logic [PW-1:0]         rd_gray_q;
    logic [PW-1:0]         wr_bin_sync;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  skid_valid_q, skid_valid_d;
    logic                  ram_empty;
    logic                  pop;
    logic                  fetch;
    logic [1:0]            used;

    always_comb begin
        wr_bin_sync = '0;
        for (int i = 0; i < PW; i++) begin
            wr_bin_sync[i] = ^(sync2_q >> i);
        end
    end

    assign ram_empty = (rd_bin_q == wr_bin_sync);
    assign pop       = out_valid_q && i_rd_ready;
    // Words already held or arriving next edge, after this cycle's pop; at most 2 can be parked.
    assign used      = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, inflight_q} - {1'b0, pop};
    assign fetch     = !ram_empty && (used < 2'd2);

    always_comb begin
        rd_bin_d     = fetch ? rd_bin_q + 1'b1 : rd_bin_q;
        inflight_d   = fetch;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;

        if (pop && skid_valid_q) begin
            out_data_d   = skid_data_q;
            out_valid_d  = 1'b1;
            skid_valid_d = inflight_q;
            if (inflight_q) begin
                skid_data_d = i_ram_data;
            end
        end else if (!out_valid_q || pop) begin
            out_valid_d = inflight_q;
            if (inflight_q) begin
                out_data_d = i_ram_data;
            end
        end else if (inflight_q) begin
            skid_data_d  = i_ram_data;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            rd_bin_q     <= '0;
            rd_gray_q    <= '0;
            inflight_q   <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            sync1_q      <= i_wr_ptr_gray;
            sync2_q      <= sync1_q;
            rd_bin_q     <= rd_bin_d;
            rd_gray_q    <= rd_bin_d ^ (rd_bin_d >> 1);
            inflight_q   <= inflight_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign o_rd_addr     = rd_bin_q[ADDR_WIDTH-1:0];
    assign o_rd_fetch    = fetch;
    assign o_rd_ptr_gray = rd_gray_q;
    assign o_data        = out_data_q;
    assign o_valid       = out_valid_q;
    assign o_empty       = !out_valid_q;
    assign o_level       = wr_bin_sync - rd_bin_q;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - scoreboard bench for fifo_rd_ctrl with write-side and RAM models
module tb_fifo_rd_ctrl;
    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW:0]   wr_ptr_gray = '0;
    logic [DW-1:0] ram_q = '0;
    logic          rd_ready = 1'b0;
    logic [AW-1:0] rd_addr;
    logic          rd_fetch;
    logic [AW:0]   rd_ptr_gray;
    logic [DW-1:0] data;
    logic          valid;
    logic          empty;
    logic [AW:0]   level;

    fifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_wr_ptr_gray(wr_ptr_gray),
        .i_ram_data   (ram_q),
        .i_rd_ready   (rd_ready),
        .o_rd_addr    (rd_addr),
        .o_rd_fetch   (rd_fetch),
        .o_rd_ptr_gray(rd_ptr_gray),
        .o_data       (data),
        .o_valid      (valid),
        .o_empty      (empty),
        .o_level      (level)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [8];
    always @(posedge clk) ram_q <= mem[rd_addr];

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] exp_q[$];
    int            wr_cnt   = 0;
    int            popped   = 0;
    int            fetch_cnt = 0;
    int            cyc = 0;
    int            first_pop_cyc = 0;
    int            last_pop_cyc = 0;
    logic [AW:0]   prev_gray = '0;
    bit            saw_wrap = 1'b0;

    task automatic chk(input string name, input bit ok, input int act, input int expv);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    function automatic logic [AW:0] to_gray(input int b);
        logic [AW:0] v;
        v = b[AW:0];
        return v ^ (v >> 1);
    endfunction

    task automatic write_word(input logic [DW-1:0] d);
        mem[wr_cnt % 8] = d;
        exp_q.push_back(d);
        wr_cnt++;
        wr_ptr_gray = to_gray(wr_cnt);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (popped < n && k < budget) begin
            step();
            k++;
        end
        chk(name, popped >= n, popped, n);
    endtask

    task automatic enter_reset(input logic [AW:0] ptr);
        rst_n = 1'b0;
        exp_q.delete();
        wr_cnt = 0;
        popped = 0;
        wr_ptr_gray = ptr;
    endtask

    // Monitor: pops expected words whenever the consumer handshake completes.
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (rd_fetch) fetch_cnt++;
            if (empty != !valid) chk("empty_vs_valid", 1'b0, empty, !valid);
            if (rd_ptr_gray != prev_gray) begin
                chk("gray_one_bit", $countones(rd_ptr_gray ^ prev_gray) == 1, rd_ptr_gray, prev_gray);
                if (prev_gray == 4'b1000 && rd_ptr_gray == 4'b0000) saw_wrap = 1'b1;
            end
            prev_gray = rd_ptr_gray;
            if (valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", 1'b0, data, 0);
                end else begin
                    chk("pop_data", data == exp_q[0], data, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                if (popped == 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                popped++;
            end
        end else begin
            prev_gray = '0;
        end
    end

    initial begin
        int k;
        int target;
        bit tog;

        // Reset with 4 entries already visible on the pointer.
        enter_reset(4'b0000);
        for (int i = 0; i < 4; i++) write_word(8'h40 + 8'(i));
        chk("ptr_is_0110", wr_ptr_gray == 4'b0110, wr_ptr_gray, 4'b0110);
        step(); step();
        chk("rst_valid", valid == 1'b0, valid, 0);
        chk("rst_empty", empty == 1'b1, empty, 1);
        chk("rst_data", data == '0, data, 0);
        chk("rst_gray", rd_ptr_gray == '0, rd_ptr_gray, 0);
        chk("rst_addr", rd_addr == '0, rd_addr, 0);
        chk("rst_fetch", rd_fetch == 1'b0, rd_fetch, 0);
        chk("rst_level", level == '0, level, 0);
        rd_ready = 1'b1;
        rst_n = 1'b1;
        step(); step();
        chk("rst_rel_not_yet_valid", valid == 1'b0, valid, 0);
        step(); step();
        chk("rst_rel_valid", valid == 1'b1, valid, 1);
        wait_pops("rst_drain", 4, 30);
        chk("rst_drain_q_empty", exp_q.size() == 0, exp_q.size(), 0);

        // Single word latency and pop.
        enter_reset(4'b0000);
        step(); step();
        rst_n = 1'b1;
        step(); step();
        write_word(8'hA5);
        step(); step(); step();
        chk("sw_not_yet_valid", valid == 1'b0, valid, 0);
        step();
        chk("sw_valid", valid == 1'b1, valid, 1);
        chk("sw_data", data == 8'hA5, data, 8'hA5);
        step();
        chk("sw_valid_drop", valid == 1'b0, valid, 0);
        chk("sw_gray", rd_ptr_gray == 4'b0001, rd_ptr_gray, 4'b0001);
        chk("sw_popped", popped == 1, popped, 1);

        // Back-to-back drain of a full RAM.
        enter_reset(4'b0000);
        step(); step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) write_word(8'h10 + 8'(i));
        wait_pops("drain_pops", 8, 40);
        step();
        chk("drain_consecutive", last_pop_cyc - first_pop_cyc == 7, last_pop_cyc - first_pop_cyc, 7);
        chk("drain_level", level == '0, level, 0);
        chk("drain_gray", rd_ptr_gray == 4'b1100, rd_ptr_gray, 4'b1100);
        chk("drain_q_empty", exp_q.size() == 0, exp_q.size(), 0);

        // Backpressure: only out and skid get filled.
        enter_reset(4'b0000);
        rd_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        fetch_cnt = 0;
        for (int i = 0; i < 8; i++) write_word(8'h60 + 8'(i));
        for (int i = 0; i < 10; i++) step();
        chk("bp_fetch_pulses", fetch_cnt == 2, fetch_cnt, 2);
        chk("bp_level", level == 4'd6, level, 6);
        chk("bp_valid", valid == 1'b1, valid, 1);
        chk("bp_data", data == 8'h60, data, 8'h60);
        chk("bp_no_pops", popped == 0, popped, 0);
        rd_ready = 1'b1;
        wait_pops("bp_pops", 8, 40);
        step(); step();
        chk("bp_q_empty", exp_q.size() == 0, exp_q.size(), 0);
        chk("bp_popped_exact", popped == 8, popped, 8);

        // Wrap-around: 20 words, ready toggling every other cycle.
        enter_reset(4'b0000);
        step(); step();
        rst_n = 1'b1;
        saw_wrap = 1'b0;
        tog = 1'b0;
        k = 0;
        while (popped < 20 && k < 400) begin
            rd_ready = tog;
            tog = !tog;
            if (wr_cnt < 20 && (wr_cnt - popped) < 8 && $urandom_range(0, 3) != 0)
                write_word(8'($urandom));
            step();
            k++;
        end
        chk("wrap_pops", popped == 20, popped, 20);
        chk("wrap_seen_15_to_0", saw_wrap, saw_wrap, 1);

        // Random ready and write traffic continuing from the wrap state.
        target = 60;
        k = 0;
        while (popped < target && k < 2000) begin
            rd_ready = 1'($urandom_range(0, 1));
            if (wr_cnt < target && (wr_cnt - popped) < 8 && $urandom_range(0, 1) == 1)
                write_word(8'($urandom));
            step();
            k++;
        end
        chk("rand_pops", popped == target, popped, target);
        step(); step();
        chk("rand_q_empty", exp_q.size() == 0, exp_q.size(), 0);

        // Asynchronous reset in the middle of streaming.
        rd_ready = 1'b1;
        for (int i = 0; i < 6; i++) write_word(8'($urandom));
        for (int i = 0; i < 5; i++) step();
        #2;
        enter_reset(4'b0000);
        #1;
        chk("mid_rst_valid", valid == 1'b0, valid, 0);
        chk("mid_rst_empty", empty == 1'b1, empty, 1);
        chk("mid_rst_gray", rd_ptr_gray == '0, rd_ptr_gray, 0);
        chk("mid_rst_addr", rd_addr == '0, rd_addr, 0);
        chk("mid_rst_level", level == '0, level, 0);
        step(); step();
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!empty) k++;
        end
        chk("mid_rst_stays_empty", k == 0, k, 0);
        chk("mid_rst_no_pops", popped == 0, popped, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
